// File: rtl/fastAdder.sv
// rtl/fastAdder.sv - L-bit carry-select adder: ripple lower L-M bits, speculate the upper M bits
module fastAdder #(
  parameter int L = 16,
  parameter int M = 8
) (
  input  logic [L-1:0] a,
  input  logic [L-1:0] b,
  input  logic         cin,
  output logic [L-1:0] sum,
  output logic         cout
);

  localparam int LO = L - M;

  logic [LO:0] lo_sum;
  logic [M:0]  hi_sum0;
  logic [M:0]  hi_sum1;

  assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
  // Both upper-segment results are formed in parallel; the lower carry only picks one.
  assign hi_sum0 = {1'b0, a[L-1:LO]} + {1'b0, b[L-1:LO]};
  assign hi_sum1 = {1'b0, a[L-1:LO]} + {1'b0, b[L-1:LO]} + {{M{1'b0}}, 1'b1};

  assign sum  = {(lo_sum[LO] ? hi_sum1[M-1:0] : hi_sum0[M-1:0]), lo_sum[LO-1:0]};
  assign cout = lo_sum[LO] ? hi_sum1[M] : hi_sum0[M];

endmodule

// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - multi-precision add/subtract, one limb per cycle through a shared fastAdder
module add_sequencer #(
  parameter int L     = 16,
  parameter int M     = 8,
  parameter int NLIMB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [NLIMB*L-1:0] a,
  input  logic [NLIMB*L-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NLIMB*L-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                state;
  logic [IW-1:0]             idx;
  logic                      carry_q;
  logic [NLIMB-1:0][L-1:0]   a_q;
  logic [NLIMB-1:0][L-1:0]   b_q;
  logic [NLIMB-1:0][L-1:0]   w_q;
  logic [L-1:0]              add_sum;
  logic                      add_cout;

  fastAdder #(.L(L), .M(M)) u_adder (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Ready is forced low while reset is held even though the FSM already sits in IDLE.
  assign start_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      w_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          w_q[idx] <= add_sum;
          carry_q  <= add_cout;
          if (idx == LAST) begin
            sum       <= {add_sum, w_q[NLIMB-2:0]};
            cout      <= add_cout;
            // Carry into the MSB is a^b^sum at that bit; XOR with carry out gives overflow.
            ovf       <= a_q[NLIMB-1][L-1] ^ b_q[NLIMB-1][L-1] ^ add_sum[L-1] ^ add_cout;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// tb/tb_add_sequencer.sv - directed self-checking bench for add_sequencer at default parameters
module tb_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  add_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold them through the accept edge; returns with start_valid low.
  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic sb);
    int n;
    n = 0;
    while (!start_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_issue", start_ready, 1'b1);
    a = av; b = bv; cin = ci; sub = sb;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    check("ready_drop_after_accept", start_ready, 1'b0);
  endtask

  task automatic wait_result(input string tag, input logic [63:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("valid_clear", res_valid, 1'b0);
    check("idle_after_consume", start_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sb,
                        input logic [63:0] es, input logic ec, input logic eo);
    issue(av, bv, ci, sb);
    wait_result(tag, es, ec, eo);
    consume();
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    check("rst_valid", res_valid, 1'b0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_ready", start_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_rst", start_ready, 1'b1);

    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("cin", 64'h1234, 64'd0, 1'b1, 1'b0, 64'h1235, 1'b0, 1'b0);
    run_op("mid_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
           64'h0001_0000_0001_0000, 1'b0, 1'b0);

    // Backpressure: result 3+4 must survive ten stalled cycles with new operands pending.
    issue(64'd3, 64'd4, 1'b0, 1'b0);
    wait_result("bp_first", 64'd7, 1'b0, 1'b0);
    a = 64'd100; b = 64'd200; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_sum_hold", sum, 64'd7);
      check("bp_valid_hold", res_valid, 1'b1);
      check("bp_ready_low", start_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_idle", start_ready, 1'b1);
    check("bp_valid_clear", res_valid, 1'b0);
    tick();
    start_valid = 1'b0;
    check("bp_accept", start_ready, 1'b0);
    wait_result("bp_second", 64'd300, 1'b0, 1'b0);
    consume();

    // Reset two cycles after accept; previous sum 300 must be wiped at once.
    issue(64'd10, 64'd20, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_sum", sum, 64'd0);
    check("mid_rst_ready", start_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_ready_after", start_ready, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        seen = seen | res_valid;
      end
      check("mid_rst_no_result", seen, 1'b0);
    end
    run_op("after_rst", 64'd40, 64'd2, 1'b0, 1'b0, 64'd42, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
